// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
// State codes, opcode values and MUX1 select encodings.
package calc_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD_A = 4'd1,
      LOAD_B = 4'd2,
      EXEC   = 4'd3,
      WAIT   = 4'd4,
      WB     = 4'd5,
      OUT    = 4'd6,
      DONE   = 4'd7,
      ERR    = 4'd8
   } state_t;

   localparam int OP_ADD        = 0;
   localparam int OP_SUB        = 1;
   localparam int OP_AND        = 2;
   localparam int OP_OR         = 3;
   localparam int OP_XOR        = 4;
   localparam int OP_LAST_LEGAL = 4;

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_IN_A = 2'd1;
   localparam logic [1:0] SEL_IN_B = 2'd2;

endpackage

// File: rtl/calc_sequencer.sv
// Control unit: load A, load B, ALU op, writeback, display; one op per go.
// Ports: clk/rst, go/op/src_a/src_b/dst in; datapath controls, CS, done/busy/err out.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int ADDR_W  = 2,
   parameter int OP_W    = 3,
   parameter int ALU_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [OP_W-1:0]   op,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   output logic [1:0]        s1,
   output logic [ADDR_W-1:0] WA,
   output logic              WE,
   output logic [ADDR_W-1:0] RAA,
   output logic [ADDR_W-1:0] RAB,
   output logic              REA,
   output logic              REB,
   output logic [OP_W-1:0]   C,
   output logic              s2,
   output logic [3:0]        CS,
   output logic              done,
   output logic              busy,
   output logic              err
);

   // WAIT runs ALU_LAT cycles: counter starts at ALU_LAT-1, exits at 0.
   localparam logic [3:0] CNT_INIT =
      (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] src_a_q;
   logic [ADDR_W-1:0] src_b_q;
   logic [ADDR_W-1:0] dst_q;
   logic [3:0]        cnt;
   logic              legal;

   assign legal = (int'(op) <= OP_LAST_LEGAL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         op_q    <= '0;
         src_a_q <= '0;
         src_b_q <= '0;
         dst_q   <= '0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  op_q    <= op;
                  src_a_q <= src_a;
                  src_b_q <= src_b;
                  dst_q   <= dst;
                  state   <= legal ? LOAD_A : ERR;
               end
            end
            LOAD_A: state <= LOAD_B;
            LOAD_B: state <= EXEC;
            EXEC: begin
               cnt   <= CNT_INIT;
               state <= (ALU_LAT == 0) ? WB : WAIT;
            end
            WAIT: begin
               if (cnt == 4'd0) state <= WB;
               else cnt <= cnt - 4'd1;
            end
            WB:   state <= OUT;
            OUT:  state <= DONE;
            // Level handshake: go must drop before another start.
            DONE: if (!go) state <= IDLE;
            ERR:  if (!go) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s1   = SEL_ALU;
      WA   = '0;
      WE   = 1'b0;
      RAA  = '0;
      RAB  = '0;
      REA  = 1'b0;
      REB  = 1'b0;
      C    = '0;
      s2   = 1'b0;
      done = 1'b0;
      busy = 1'b0;
      err  = 1'b0;
      CS   = state;
      unique case (state)
         IDLE: ;
         LOAD_A: begin
            busy = 1'b1;
            s1   = SEL_IN_A;
            WA   = src_a_q;
            WE   = 1'b1;
         end
         LOAD_B: begin
            busy = 1'b1;
            s1   = SEL_IN_B;
            WA   = src_b_q;
            WE   = 1'b1;
         end
         EXEC, WAIT: begin
            busy = 1'b1;
            REA  = 1'b1;
            REB  = 1'b1;
            RAA  = src_a_q;
            RAB  = src_b_q;
            C    = op_q;
         end
         WB: begin
            busy = 1'b1;
            REA  = 1'b1;
            REB  = 1'b1;
            RAA  = src_a_q;
            RAB  = src_b_q;
            C    = op_q;
            s1   = SEL_ALU;
            WA   = dst_q;
            WE   = 1'b1;
         end
         OUT: begin
            busy = 1'b1;
            REA  = 1'b1;
            RAA  = dst_q;
            s2   = 1'b1;
         end
         DONE: begin
            REA  = 1'b1;
            RAA  = dst_q;
            s2   = 1'b1;
            done = 1'b1;
         end
         ERR: err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer, ALU_LAT=0 and ALU_LAT=3 side by side.
// Expected writes/done/err events are queued at issue and popped by a monitor.
module tb_calc_sequencer;

   typedef struct packed {
      logic [1:0] s1;
      logic [1:0] wa;
      logic       we;
      logic [1:0] raa;
      logic [1:0] rab;
      logic       rea;
      logic       reb;
      logic [2:0] c;
      logic       s2;
      logic [3:0] cs;
      logic       done;
      logic       busy;
      logic       err;
   } out_t;

   typedef struct {
      int cyc;
      int wa;
      int s1;
      int c;
   } wev_t;

   typedef struct {
      int cyc;
      int raa;
      int op;
   } dev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       go  = 1'b0;
   logic [2:0] op  = '0;
   logic [1:0] src_a = '0;
   logic [1:0] src_b = '0;
   logic [1:0] dst   = '0;

   logic [1:0] s1_0, wa_0, raa_0, rab_0, s1_3, wa_3, raa_3, rab_3;
   logic       we_0, rea_0, reb_0, s2_0, done_0, busy_0, err_0;
   logic       we_3, rea_3, reb_3, s2_3, done_3, busy_3, err_3;
   logic [2:0] c_0, c_3;
   logic [3:0] cs_0, cs_3;

   out_t o [2];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   wev_t wq [2][$];
   dev_t dq [2][$];
   int   eq [2][$];
   int   wcnt [2];
   bit   dprev [2];
   bit   eprev [2];
   wev_t w;
   dev_t d;
   int   e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   calc_sequencer #(.ADDR_W(2), .OP_W(3), .ALU_LAT(0)) u0 (
      .clk(clk), .rst(rst), .go(go), .op(op),
      .src_a(src_a), .src_b(src_b), .dst(dst),
      .s1(s1_0), .WA(wa_0), .WE(we_0), .RAA(raa_0), .RAB(rab_0),
      .REA(rea_0), .REB(reb_0), .C(c_0), .s2(s2_0), .CS(cs_0),
      .done(done_0), .busy(busy_0), .err(err_0)
   );

   calc_sequencer #(.ADDR_W(2), .OP_W(3), .ALU_LAT(3)) u3 (
      .clk(clk), .rst(rst), .go(go), .op(op),
      .src_a(src_a), .src_b(src_b), .dst(dst),
      .s1(s1_3), .WA(wa_3), .WE(we_3), .RAA(raa_3), .RAB(rab_3),
      .REA(rea_3), .REB(reb_3), .C(c_3), .s2(s2_3), .CS(cs_3),
      .done(done_3), .busy(busy_3), .err(err_3)
   );

   assign o[0] = {s1_0, wa_0, we_0, raa_0, rab_0, rea_0, reb_0,
                  c_0, s2_0, cs_0, done_0, busy_0, err_0};
   assign o[1] = {s1_3, wa_3, we_3, raa_3, rab_3, rea_3, reb_3,
                  c_3, s2_3, cs_3, done_3, busy_3, err_3};

   function automatic int lat(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected events whenever a DUT presents WE, done or err.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (o[i].we) begin
            if (wq[i].size() == 0) begin
               chk($sformatf("u%0d unexpected_we", i), 1, 0);
            end else begin
               w = wq[i].pop_front();
               chk($sformatf("u%0d we_cycle", i), cyc, w.cyc);
               chk($sformatf("u%0d wa", i), int'(o[i].wa), w.wa);
               chk($sformatf("u%0d s1", i), int'(o[i].s1), w.s1);
               if (w.s1 == 0)
                  chk($sformatf("u%0d wb_c", i), int'(o[i].c), w.c);
            end
         end
         if (o[i].reb && dq[i].size() != 0)
            chk($sformatf("u%0d exec_c", i), int'(o[i].c), dq[i][0].op);
         if (o[i].cs == 4'd4) wcnt[i]++;
         if (o[i].done && !dprev[i]) begin
            if (dq[i].size() == 0) begin
               chk($sformatf("u%0d unexpected_done", i), 1, 0);
            end else begin
               d = dq[i].pop_front();
               chk($sformatf("u%0d done_cycle", i), cyc, d.cyc);
               chk($sformatf("u%0d done_raa", i), int'(o[i].raa), d.raa);
               chk($sformatf("u%0d done_s2", i), int'(o[i].s2), 1);
               chk($sformatf("u%0d done_rea", i), int'(o[i].rea), 1);
               chk($sformatf("u%0d done_busy", i), int'(o[i].busy), 0);
               chk($sformatf("u%0d wait_cycles", i), wcnt[i], lat(i));
            end
            wcnt[i] = 0;
         end
         if (o[i].err && !eprev[i]) begin
            if (eq[i].size() == 0) begin
               chk($sformatf("u%0d unexpected_err", i), 1, 0);
            end else begin
               e = eq[i].pop_front();
               chk($sformatf("u%0d err_cycle", i), cyc, e);
               chk($sformatf("u%0d err_cs", i), int'(o[i].cs), 8);
            end
            wcnt[i] = 0;
         end
         dprev[i] = o[i].done;
         eprev[i] = o[i].err;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One go handshake. Events are predicted from the op's timeline:
   // writes at base, base+1, base+3+lat; done at base+5+lat.
   task automatic run_op(input int opv, input int a, input int b,
                         input int dv, input int hold, input bit chg,
                         input int nop, input int ndst);
      int  base;
      int  t;
      bit  legal;
      step();
      op    = 3'(opv);
      src_a = 2'(a);
      src_b = 2'(b);
      dst   = 2'(dv);
      go    = 1'b1;
      base  = cyc + 1;
      legal = (opv <= 4);
      for (int i = 0; i < 2; i++) begin
         if (legal) begin
            wq[i].push_back('{base, a, 1, opv});
            wq[i].push_back('{base + 1, b, 2, opv});
            wq[i].push_back('{base + 3 + lat(i), dv, 0, opv});
            dq[i].push_back('{base + 5 + lat(i), dv, opv});
         end else begin
            eq[i].push_back(base);
         end
      end
      step();
      for (int i = 0; i < 2; i++)
         chk($sformatf("u%0d busy_start", i), int'(o[i].busy), int'(legal));
      if (chg) begin
         step();
         op  = 3'(nop);
         dst = 2'(ndst);
      end
      t = 0;
      while (!((o[0].done || o[0].err) && (o[1].done || o[1].err))
             && t < 40) begin
         step();
         t++;
      end
      if (t >= 40) chk("completion_timeout", t, 0);
      repeat (hold) step();
      for (int i = 0; i < 2; i++)
         chk($sformatf("u%0d hold_cs", i), int'(o[i].cs), legal ? 7 : 8);
      go = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d idle_cs", i), int'(o[i].cs), 0);
         chk($sformatf("u%0d idle_done", i), int'(o[i].done), 0);
         chk($sformatf("u%0d idle_err", i), int'(o[i].err), 0);
         chk($sformatf("u%0d wq_left", i), wq[i].size(), 0);
         chk($sformatf("u%0d dq_left", i), dq[i].size(), 0);
         chk($sformatf("u%0d eq_left", i), eq[i].size(), 0);
         wq[i].delete();
         dq[i].delete();
         eq[i].delete();
      end
   endtask

   // Abort an ADD in LOAD_B; the WB write and done must never appear.
   task automatic reset_mid_op();
      int base;
      step();
      op    = 3'd0;
      src_a = 2'd0;
      src_b = 2'd1;
      dst   = 2'd2;
      go    = 1'b1;
      base  = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         wq[i].push_back('{base, 0, 1, 0});
         wq[i].push_back('{base + 1, 1, 2, 0});
      end
      step();
      step();
      for (int i = 0; i < 2; i++)
         chk($sformatf("u%0d pre_reset_cs", i), int'(o[i].cs), 2);
      rst = 1'b0;
      go  = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d reset_outputs", i), int'(o[i]), 0);
         wcnt[i] = 0;
      end
      step();
      rst = 1'b1;
      repeat (6) step();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d post_reset_cs", i), int'(o[i].cs), 0);
         chk($sformatf("u%0d post_reset_done", i), int'(o[i].done), 0);
         chk($sformatf("u%0d post_reset_wq", i), wq[i].size(), 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         wcnt[i]  = 0;
         dprev[i] = 1'b0;
         eprev[i] = 1'b0;
      end
      rst = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 2; i++)
         chk($sformatf("u%0d reset_state", i), int'(o[i]), 0);
      rst = 1'b1;
      step();

      // ADD 0,1 -> 2 with go held a few cycles past done.
      run_op(0, 0, 1, 2, 3, 1'b0, 0, 0);
      // XOR exercises WAIT on the latency-3 instance.
      run_op(4, 2, 3, 1, 0, 1'b0, 0, 0);
      // Illegal opcode.
      run_op(6, 1, 2, 3, 2, 1'b0, 0, 0);
      // Retrigger guard: go held 20 cycles after done.
      run_op(3, 3, 0, 1, 20, 1'b0, 0, 0);
      // Latch isolation: op/dst change to 1/3 mid-op; src_a == src_b.
      run_op(2, 1, 1, 0, 1, 1'b1, 1, 3);
      // Reset while in LOAD_B.
      reset_mid_op();
      run_op(1, 3, 2, 0, 0, 1'b0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         run_op(int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
